// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: round-robin scheduler for two requesters sharing one mode-0 SPI link.
// Optional macro SPI_LOOPBACK_EN adds a loopback input that samples mosi instead of miso.
module spi_xfer_sched #(
  parameter int CLK_DIV = 750,
  parameter int FRAME_W = 16,
  parameter int CS_GAP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [FRAME_W-1:0] tx_data0,
  input  logic [FRAME_W-1:0] tx_data1,
  output logic [1:0]         gnt,
  output logic               busy,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_owner,
  output logic               sclk,
  output logic               mosi,
  input  logic               miso,
`ifdef SPI_LOOPBACK_EN
  input  logic               loopback,
`endif
  output logic               cs_n
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(FRAME_W + 1);
  localparam int GAP_W = $clog2(CS_GAP + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               ptr_q, ptr_d;
  logic [FRAME_W-1:0] tx_sh_q, tx_sh_d;
  logic [FRAME_W-1:0] rx_sh_q, rx_sh_d;
  logic [1:0]         gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rx_owner_q, rx_owner_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               cs_n_q, cs_n_d;
  logic               tick;
  logic               sample_bit;
  logic               win;

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

`ifdef SPI_LOOPBACK_EN
  assign sample_bit = loopback ? mosi_q : miso;
`else
  assign sample_bit = miso;
`endif

  always_comb begin
    // With both requesting, the one not served last wins.
    win        = (req == 2'b11) ? ~ptr_q : req[1];
    state_d    = state_q;
    div_d      = tick ? '0 : div_q + DIV_W'(1);
    bit_d      = bit_q;
    gap_d      = gap_q;
    ptr_d      = ptr_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    gnt_d      = 2'b00;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_owner_d = rx_owner_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (req != 2'b00) begin
          gnt_d   = win ? 2'b10 : 2'b01;
          tx_sh_d = win ? tx_data1 : tx_data0;
          mosi_d  = tx_sh_d[FRAME_W-1];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          ptr_d   = win;
          bit_d   = '0;
          sclk_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_sh_d = {rx_sh_q[FRAME_W-2:0], sample_bit};
            bit_d   = bit_q + BIT_W'(1);
          end else begin
            tx_sh_d = tx_sh_q << 1;
            mosi_d  = tx_sh_q[FRAME_W-2];
            if (bit_q == BIT_W'(FRAME_W)) state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_n_d     = 1'b1;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          rx_owner_d = ptr_q;
          gap_d      = '0;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_q == GAP_W'(CS_GAP - 1)) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      ptr_q      <= 1'b1;
      gnt_q      <= 2'b00;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_owner_q <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_owner_q <= rx_owner_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
    // Shift registers carry only data; they are reloaded on every grant.
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_owner = rx_owner_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
endmodule

// File: tb/tb_spi_xfer_sched.sv
// Scoreboard bench for spi_xfer_sched: a small fast instance for protocol checks plus a
// default-parameter instance for absolute SCLK/CS timing.
module tb_spi_xfer_sched;
  localparam int CD = 4;
  localparam int FW = 16;
  localparam int CG = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req = 2'b00;
  logic [FW-1:0] tx_data0 = '0, tx_data1 = '0;
  logic [1:0]    gnt;
  logic          busy, rx_valid, rx_owner, sclk, mosi, cs_n;
  logic [FW-1:0] rx_data;
  logic          miso = 1'b0;
  logic          loopback = 1'b0;

  logic [1:0]  req_df = 2'b00;
  logic [15:0] tx0_df = '0;
  logic [1:0]  gnt_df;
  logic        busy_df, rxv_df, rxo_df, sclk_df, mosi_df, cs_df;
  logic [15:0] rx_df;
  logic        lb_df = 1'b0;

  always #5 clk = ~clk;

  spi_xfer_sched #(.CLK_DIV(CD), .FRAME_W(FW), .CS_GAP(CG)) dut (
    .clk(clk), .rst(rst), .req(req), .tx_data0(tx_data0), .tx_data1(tx_data1),
    .gnt(gnt), .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid), .rx_owner(rx_owner),
    .sclk(sclk), .mosi(mosi), .miso(miso),
`ifdef SPI_LOOPBACK_EN
    .loopback(loopback),
`endif
    .cs_n(cs_n));

  spi_xfer_sched dut_def (
    .clk(clk), .rst(rst), .req(req_df), .tx_data0(tx0_df), .tx_data1(16'h0000),
    .gnt(gnt_df), .busy(busy_df), .rx_data(rx_df), .rx_valid(rxv_df), .rx_owner(rxo_df),
    .sclk(sclk_df), .mosi(mosi_df), .miso(1'b1),
`ifdef SPI_LOOPBACK_EN
    .loopback(lb_df),
`endif
    .cs_n(cs_df));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic owner; logic [FW-1:0] rx; } exp_t;
  exp_t          exp_q[$];
  logic [FW-1:0] txexp_q[$];
  logic [FW-1:0] slave_q[$];
  logic          last_served = 1'b1;
  int            csrise_cyc = 0;
  int            busy_fall_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req_v, $time);
    end
  endtask

  // Mode-0 slave: drives miso after each falling sclk, captures mosi on each rising sclk.
  logic          cs_prev = 1'b1, sclk_prev = 1'b0, sl_act = 1'b0, seen_rise = 1'b0;
  logic [FW-1:0] sl_out = '0, sl_cap = '0, txe;
  int            cs_len = 0, nrise = 0;
  always @(negedge clk) begin
    if (rst) begin
      sl_act = 1'b0;
      miso   = 1'b0;
    end else begin
      if (cs_prev && !cs_n) begin
        sl_act = 1'b1; cs_len = 0; nrise = 0; seen_rise = 1'b0;
        sl_out = (slave_q.size() != 0) ? slave_q.pop_front() : '0;
        miso   = sl_out[FW-1];
      end
      if (sl_act && !sclk_prev && sclk) begin
        sl_cap = {sl_cap[FW-2:0], mosi};
        nrise++;
        if (!seen_rise) begin
          seen_rise = 1'b1;
          chk("first_sclk_rise_delay", 32'(cs_len), 32'(CD));
        end
      end
      if (sl_act && sclk_prev && !sclk) begin
        sl_out = sl_out << 1;
        miso   = sl_out[FW-1];
      end
      if (sl_act && !cs_prev && cs_n) begin
        sl_act     = 1'b0;
        csrise_cyc = cyc;
        chk("cs_low_cycles", 32'(cs_len), 32'((2*FW+1)*CD));
        chk("sclk_rises", 32'(nrise), 32'(FW));
        if (txexp_q.size() == 0) chk("mosi_frame_unexpected", 32'(sl_cap), 32'hDEAD_BEEF);
        else begin
          txe = txexp_q.pop_front();
          chk("mosi_frame", 32'(sl_cap), 32'(txe));
        end
      end
      if (!cs_n) cs_len++;
    end
    cs_prev   = cs_n;
    sclk_prev = sclk;
  end

  // Scoreboard monitor: every rx_valid pops one expected frame.
  logic busy_prev = 1'b0;
  exp_t e_mon;
  always @(negedge clk) begin
    if (!rst) begin
      if (busy_prev && !busy) busy_fall_cyc = cyc;
      if (rx_valid && gnt != 2'b00) chk("gnt_with_rx_valid", 32'(gnt), 32'h0);
      if (rx_valid) begin
        if (exp_q.size() == 0) chk("rx_valid_unexpected", 32'(rx_data), 32'hDEAD_BEEF);
        else begin
          e_mon = exp_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(e_mon.rx));
          chk("rx_owner", 32'(rx_owner), 32'(e_mon.owner));
        end
      end
    end
    busy_prev = busy;
  end

  task automatic wait_gnt(output logic [1:0] g, output int t);
    g = 2'b00; t = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin g = gnt; t = cyc; return; end
    end
    chk("gnt_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle_timeout", 32'(busy), 32'h0);
  endtask

  // Expected grant order comes from the round-robin rule applied to the request mask.
  task automatic xfer(input logic [1:0] mask, input logic [FW-1:0] d0, d1, s0, s1,
                      input logic lb);
    logic [1:0] g;
    int t, tprev, n;
    logic wins[2];
    exp_t e;
    n = (mask == 2'b11) ? 2 : 1;
    wins[0] = (mask == 2'b11) ? ~last_served : mask[1];
    wins[1] = ~wins[0];
    tprev = 0;
    for (int k = 0; k < n; k++) begin
      e.owner = wins[k];
      e.rx    = lb ? (wins[k] ? d1 : d0) : (wins[k] ? s1 : s0);
      exp_q.push_back(e);
      txexp_q.push_back(wins[k] ? d1 : d0);
      slave_q.push_back(wins[k] ? s1 : s0);
    end
    tx_data0 = d0; tx_data1 = d1; loopback = lb; req = mask;
    for (int k = 0; k < n; k++) begin
      wait_gnt(g, t);
      chk("gnt", 32'(g), wins[k] ? 32'h2 : 32'h1);
      chk("busy_at_gnt", 32'(busy), 32'h1);
      if (k == 1) chk("gnt_to_gnt", 32'(t - tprev), 32'((2*FW+1+CG)*CD+1));
      tprev = t;
      req = req & ~g;
      last_served = wins[k];
    end
    wait_idle();
    loopback = 1'b0;
  endtask

  logic [1:0] g;
  int t, n, cnt, r1, f1, r2;
  logic sp;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_rx_owner", 32'(rx_owner), 32'h0);
    chk("rst_sclk", 32'(sclk), 32'h0);
    chk("rst_mosi", 32'(mosi), 32'h0);
    chk("rst_cs_n", 32'(cs_n), 32'h1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Simultaneous requests: 0 then 1, then a third round starts with 0 again.
    xfer(2'b11, 16'h1357, 16'h2468, 16'h0F0F, 16'hF0F0, 1'b0);
    xfer(2'b11, 16'h8001, 16'h7FFE, 16'hAAAA, 16'h5555, 1'b0);
    // Single transfer from requester 0.
    xfer(2'b01, 16'hA55A, 16'h0000, 16'h3C0F, 16'h0000, 1'b0);

    // Request from 1 raised mid-frame while requester 0 is being served.
    begin
      exp_t e;
      logic [FW-1:0] d0, d1, s0, s1;
      d0 = FW'($urandom); d1 = FW'($urandom); s0 = FW'($urandom); s1 = FW'($urandom);
      e.owner = 1'b0; e.rx = s0; exp_q.push_back(e);
      e.owner = 1'b1; e.rx = s1; exp_q.push_back(e);
      txexp_q.push_back(d0); txexp_q.push_back(d1);
      slave_q.push_back(s0); slave_q.push_back(s1);
      tx_data0 = d0; req = 2'b01;
      wait_gnt(g, t);
      chk("busy_req_gnt0", 32'(g), 32'h1);
      req = 2'b00; last_served = 1'b0;
      repeat (40) @(negedge clk);
      tx_data1 = d1; req = 2'b10;
      wait_gnt(g, t);
      chk("busy_req_gnt1", 32'(g), 32'h2);
      chk("csrise_to_idle", 32'(busy_fall_cyc - csrise_cyc), 32'(CG*CD));
      chk("csrise_to_gnt", 32'(t - csrise_cyc), 32'(CG*CD+1));
      req = 2'b00; last_served = 1'b1;
      wait_idle();
    end

    for (int i = 0; i < 10; i++) begin
      xfer(2'($urandom_range(3, 1)), FW'($urandom), FW'($urandom), FW'($urandom),
           FW'($urandom), 1'b0);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end

    // Reset after 7 bits of a requester-0 frame; pointer must return to 1.
    tx_data0 = FW'($urandom); req = 2'b01;
    wait_gnt(g, t);
    req = 2'b00; last_served = 1'b0;
    n = 0; sp = 1'b0;
    for (int i = 0; i < 500 && n < 7; i++) begin
      @(negedge clk);
      if (!sp && sclk) n++;
      sp = sclk;
    end
    repeat (CD) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cs_n", 32'(cs_n), 32'h1);
    chk("midrst_sclk", 32'(sclk), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_rx_valid", 32'(rx_valid), 32'h0);
    chk("midrst_rx_data", 32'(rx_data), 32'h0);
    rst = 1'b0; last_served = 1'b1;
    @(negedge clk);
    xfer(2'b11, FW'($urandom), 16'h00FF, FW'($urandom), FW'($urandom), 1'b0);

`ifdef SPI_LOOPBACK_EN
    xfer(2'b01, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b1);
`endif

    // Default parameters: absolute SCLK and CS timing.
    req_df = 2'b01; tx0_df = 16'hBEEF;
    g = 2'b00;
    for (int i = 0; i < 100 && g == 2'b00; i++) begin
      @(negedge clk);
      g = gnt_df;
    end
    chk("dfl_gnt", 32'(g), 32'h1);
    req_df = 2'b00;
    cnt = 0; r1 = -1; f1 = -1; r2 = -1; sp = 1'b0;
    for (int i = 0; i < 30000 && !cs_df; i++) begin
      if (!sp && sclk_df) begin
        if (r1 < 0) r1 = cnt;
        else if (r2 < 0) r2 = cnt;
      end
      if (sp && !sclk_df && f1 < 0) f1 = cnt;
      sp = sclk_df;
      cnt++;
      @(negedge clk);
    end
    chk("dfl_cs_low", 32'(cnt), 32'd24750);
    chk("dfl_first_rise", 32'(r1), 32'd750);
    chk("dfl_sclk_high", 32'(f1 - r1), 32'd750);
    chk("dfl_sclk_low", 32'(r2 - f1), 32'd750);
    chk("dfl_rx_valid", 32'(rxv_df), 32'h1);
    chk("dfl_rx_data", 32'(rx_df), 32'hFFFF);
    chk("dfl_rx_owner", 32'(rxo_df), 32'h0);

    repeat (5) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    chk("txexp_q_drained", 32'(txexp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
